z80_isr_tracker: RTL
====================

// Module: z80_isr_tracker
// PURPOSE
//  Clocked, parametrised Z80 instruction-boundary tracker; watches opcode fetches (M1) on the CPU bus.
//  Decodes full prefix chains (CB, ED, DD/FD, DDCB/FDCB); flags instruction start, jump class and I/O direction.
//  Sits beside the MegaMapper bank logic, which consumes isr_start / jmp_hit to time mapping switches.
// PARAMETERS
//  SYNC_STAGES  2     synchroniser depth for m1_n/iorq_n (>=2)
//  JMP_MASK     4'b0001  jump classes flagged: [0] JP nn C3, [1] JP cc C2..FA, [2] JR 18/20..38, [3] CALL nn CD
//  HIST_DEPTH   8     opcode history entries (power of 2, 2..32); used only with OPCODE_HIST_EN
// PORTS
//  clk          in   1  system clock
//  rst          in   1  synchronous reset, active high
//  m1_n         in   1  CPU M1, async to clk
//  iorq_n       in   1  CPU IORQ, async; M1&IORQ low = interrupt ack, not a fetch
//  data         in   8  CPU data bus
//  ignore_next  in   1  suppress jmp_hit for the instruction completing on this fetch
//  isr_start    out  1  1-cycle pulse: completed fetch was first opcode byte of a new instruction
//  isr_done     out  1  level: last fetch completed an instruction (no further M1 bytes pending)
//  prefix       out  3  class of current instruction: 0 none,1 CB,2 ED,3 DD,4 FD,5 DDCB,6 FDCB
//  jmp_hit      out  1  level: completed instruction is in JMP_MASK and ignore_next was low
//  io_dir       out  1  1 = IN, 0 = OUT; valid only for I/O opcodes
//  fetch_cnt    out  8  completed opcode fetches since reset, wraps 255->0
//  hist_rd_idx  in   $clog2(HIST_DEPTH)  history index, 0 = newest (OPCODE_HIST_EN only)
//  hist_rd_data out  8  opcode at hist_rd_idx, combinational from buffer (OPCODE_HIST_EN only)
// BEHAVIOUR
//  - Reset: isr_start=0, isr_done=1, prefix=0, jmp_hit=0, io_dir=0, fetch_cnt=0, FSM=BASE, sync chains=1.
//  - m1_n/iorq_n pass SYNC_STAGES flops; data captured every clk while synced m1_n=0 (last low sample held).
//  - Fetch completion = synced m1_n rising edge with iorq_n high during the low phase; ack cycles ignored.
//  - All outputs update on the clk after completion (latency SYNC_STAGES+1 clk from m1_n rise).
//  - FSM states BASE, PFX_CB, PFX_ED, PFX_IDX (remembers DD/FD); transitions on completion byte b:
//    BASE: CB->PFX_CB, ED->PFX_ED, DD/FD->PFX_IDX; else stay, instruction done. isr_start=1 on every BASE fetch.
//    PFX_CB / PFX_ED: any b -> BASE, instruction done (ED ED counts as ED+opcode, no chaining).
//    PFX_IDX: DD/FD -> PFX_IDX (new prefix replaces old, isr_start=1 again); ED -> PFX_ED (prefix=2);
//      CB -> BASE, done, prefix=5/6 (displacement+opcode are non-M1 reads); other b -> BASE, done.
//  - isr_done=1 only on completion that returns FSM to BASE; 0 while a prefix is pending.
//  - jmp_hit evaluated on final byte with prefix none or DD/FD (DD C3 counts); cleared at next completion.
//  - io_dir: base DB->1, D3->0; ED page: b[0] inverted (40..7F, A2/A3/AA/AB/B2/B3/BA/BB); else holds.
//  - fetch_cnt increments once per completion, ack cycles excluded; 8-bit wrap.
//  - Reset mid-instruction returns FSM to BASE; next fetch is a new instruction.
//  - Two completions cannot occur closer than SYNC_STAGES+1 clk; clk >= 4x CPU clock is required.
// CONFIGURATION
//  - OPCODE_HIST_EN defined: HIST_DEPTH x 8 ring buffer, write pointer advances on every completion
//    (wrap at HIST_DEPTH-1->0), reset clears pointer and entries to 00. Undefined: no buffer, hist_rd_data=00.
// STRUCTURE
//  - Shared package z80_pkg: opcode constants (OP_CB, OP_ED, OP_DD, OP_FD, OP_JP, OP_IN, OP_OUT), prefix enum codes, JMP class bits.
//  - One sub-module natural: z80_sync (SYNC_STAGES flop chain, reset value 1), instanced for m1_n and iorq_n.
// TESTING
//  - Reset then fetch 3E,00 -> isr_start pulses each, isr_done=1, prefix=0, fetch_cnt=2.
//  - Fetch DD,CB (then 2 non-M1 reads), 00 -> prefix=5 after CB, isr_done=1, next fetch isr_start=1, prefix=0.
//  - Fetch DD,FD,21 -> isr_start on DD and FD, isr_done=0,0,1, prefix=4 at end.
//  - Fetch C3 with ignore_next=0 -> jmp_hit=1; C3 with ignore_next=1 -> jmp_hit=0; JMP_MASK=4'b0100, 18 -> jmp_hit=1.
//  - Fetch DB -> io_dir=1; ED,79 -> io_dir=0; ED,A2 -> io_dir=1; M1+IORQ ack with data FF -> no count change.
//  - OPCODE_HIST_EN, HIST_DEPTH=8: fetch 01..0A -> idx0=0A, idx7=03; rst asserted after ED -> next CB decoded as BASE prefix.

Source files
------------

// File: rtl/z80_pkg.sv
// Shared Z80 decode constants: opcode bytes, prefix class codes, jump class bits.
// Helpers classify jump opcodes and the ED-page I/O group.
package z80_pkg;

  localparam logic [7:0] OP_CB   = 8'hCB;
  localparam logic [7:0] OP_ED   = 8'hED;
  localparam logic [7:0] OP_DD   = 8'hDD;
  localparam logic [7:0] OP_FD   = 8'hFD;
  localparam logic [7:0] OP_JP   = 8'hC3;
  localparam logic [7:0] OP_CALL = 8'hCD;
  localparam logic [7:0] OP_IN   = 8'hDB;
  localparam logic [7:0] OP_OUT  = 8'hD3;

  localparam int JC_JP   = 0;
  localparam int JC_JPCC = 1;
  localparam int JC_JR   = 2;
  localparam int JC_CALL = 3;

  typedef enum logic [2:0] {
    PFX_NONE = 3'd0,
    PFX_CB   = 3'd1,
    PFX_ED   = 3'd2,
    PFX_DD   = 3'd3,
    PFX_FD   = 3'd4,
    PFX_DDCB = 3'd5,
    PFX_FDCB = 3'd6
  } pfx_e;

  typedef enum logic [1:0] {
    ST_BASE,
    ST_PFX_CB,
    ST_PFX_ED,
    ST_PFX_IDX
  } st_e;

  // JP cc is 11ccc010, JR is 18 or 001cc000
  function automatic logic [3:0] jmp_class(input logic [7:0] b);
    logic [3:0] c;
    c          = '0;
    c[JC_JP]   = (b == OP_JP);
    c[JC_JPCC] = ((b & 8'hC7) == 8'hC2);
    c[JC_JR]   = (b == 8'h18) || ((b[7:5] == 3'b001) && (b[2:0] == 3'b000));
    c[JC_CALL] = (b == OP_CALL);
    return c;
  endfunction

  // ED 40..7F plus block I/O (A2/A3/AA/AB/B2/B3/BA/BB): bit0 clear means IN
  function automatic logic ed_io_op(input logic [7:0] b);
    return (b[7:6] == 2'b01) || ((b & 8'hE6) == 8'hA2);
  endfunction

endpackage

// File: rtl/z80_sync.sv
// Multi-flop synchroniser for an asynchronous active-low CPU strobe; resets to idle (1).
module z80_sync #(
  parameter int STAGES = 2
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_d,
  output logic o_q
);

  logic [STAGES-1:0] r_chain;

  always_ff @(posedge i_clk) begin
    if (i_rst) r_chain <= '1;
    else       r_chain <= {r_chain[STAGES-2:0], i_d};
  end

  assign o_q = r_chain[STAGES-1];

endmodule

// File: rtl/z80_isr_tracker.sv
// Z80 instruction-boundary tracker: follows M1 fetches through prefix chains.
// Optional opcode history ring buffer enabled by defining OPCODE_HIST_EN.
module z80_isr_tracker
  import z80_pkg::*;
#(
  parameter int         SYNC_STAGES = 2,
  parameter logic [3:0] JMP_MASK    = 4'b0001,
  parameter int         HIST_DEPTH  = 8
) (
  input  logic                          i_clk,
  input  logic                          i_rst,
  input  logic                          i_m1_n,
  input  logic                          i_iorq_n,
  input  logic [7:0]                    i_data,
  input  logic                          i_ignore_next,
  output logic                          o_isr_start,
  output logic                          o_isr_done,
  output logic [2:0]                    o_prefix,
  output logic                          o_jmp_hit,
  output logic                          o_io_dir,
  output logic [7:0]                    o_fetch_cnt,
  input  logic [$clog2(HIST_DEPTH)-1:0] i_hist_rd_idx,
  output logic [7:0]                    o_hist_rd_data
);

  localparam int AW = $clog2(HIST_DEPTH);

  logic       w_m1s, w_iorqs;
  logic       r_m1_prev, r_ack;
  logic [7:0] r_data;
  logic       w_done;
  logic [7:0] w_byte;
  logic       w_jmp;
  logic       w_io_hit, w_io_val;

  st_e        r_state;
  pfx_e       r_prefix;
  logic       r_isr_start, r_isr_done, r_jmp_hit, r_io_dir;
  logic [7:0] r_fetch_cnt;

  z80_sync #(.STAGES(SYNC_STAGES)) u_sync_m1 (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .i_d   (i_m1_n),
    .o_q   (w_m1s)
  );

  z80_sync #(.STAGES(SYNC_STAGES)) u_sync_iorq (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .i_d   (i_iorq_n),
    .o_q   (w_iorqs)
  );

  // The opcode byte is the last data sample taken while M1 was low; an
  // IORQ seen anywhere in the low phase marks an interrupt acknowledge.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_m1_prev <= 1'b1;
      r_ack     <= 1'b0;
      r_data    <= 8'h00;
    end else begin
      r_m1_prev <= w_m1s;
      if (!w_m1s) r_data <= i_data;
      if (!w_m1s && !w_iorqs) r_ack <= 1'b1;
      else if (w_m1s)         r_ack <= 1'b0;
    end
  end

  assign w_done   = w_m1s & ~r_m1_prev & ~r_ack;
  assign w_byte   = r_data;
  assign w_jmp    = (|(jmp_class(w_byte) & JMP_MASK)) & ~i_ignore_next;
  assign w_io_hit = (w_byte == OP_IN) || (w_byte == OP_OUT);
  assign w_io_val = (w_byte == OP_IN);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= ST_BASE;
      r_prefix    <= PFX_NONE;
      r_isr_start <= 1'b0;
      r_isr_done  <= 1'b1;
      r_jmp_hit   <= 1'b0;
      r_io_dir    <= 1'b0;
      r_fetch_cnt <= 8'h00;
    end else begin
      r_isr_start <= 1'b0;
      if (w_done) begin
        r_fetch_cnt <= r_fetch_cnt + 8'd1;
        r_jmp_hit   <= 1'b0;
        case (r_state)
          ST_BASE: begin
            r_isr_start <= 1'b1;
            case (w_byte)
              OP_CB: begin
                r_state    <= ST_PFX_CB;
                r_prefix   <= PFX_CB;
                r_isr_done <= 1'b0;
              end
              OP_ED: begin
                r_state    <= ST_PFX_ED;
                r_prefix   <= PFX_ED;
                r_isr_done <= 1'b0;
              end
              OP_DD, OP_FD: begin
                r_state    <= ST_PFX_IDX;
                r_prefix   <= (w_byte == OP_FD) ? PFX_FD : PFX_DD;
                r_isr_done <= 1'b0;
              end
              default: begin
                r_prefix   <= PFX_NONE;
                r_isr_done <= 1'b1;
                r_jmp_hit  <= w_jmp;
                if (w_io_hit) r_io_dir <= w_io_val;
              end
            endcase
          end
          ST_PFX_CB: begin
            r_state    <= ST_BASE;
            r_isr_done <= 1'b1;
          end
          ST_PFX_ED: begin
            r_state    <= ST_BASE;
            r_isr_done <= 1'b1;
            if (ed_io_op(w_byte)) r_io_dir <= ~w_byte[0];
          end
          ST_PFX_IDX: begin
            case (w_byte)
              // A repeated index prefix discards the earlier one
              OP_DD, OP_FD: begin
                r_isr_start <= 1'b1;
                r_prefix    <= (w_byte == OP_FD) ? PFX_FD : PFX_DD;
              end
              OP_ED: begin
                r_state  <= ST_PFX_ED;
                r_prefix <= PFX_ED;
              end
              // DDCB/FDCB: displacement and opcode follow as plain reads
              OP_CB: begin
                r_state    <= ST_BASE;
                r_isr_done <= 1'b1;
                r_prefix   <= (r_prefix == PFX_FD) ? PFX_FDCB : PFX_DDCB;
              end
              default: begin
                r_state    <= ST_BASE;
                r_isr_done <= 1'b1;
                r_jmp_hit  <= w_jmp;
                if (w_io_hit) r_io_dir <= w_io_val;
              end
            endcase
          end
          default: r_state <= ST_BASE;
        endcase
      end
    end
  end

  assign o_isr_start = r_isr_start;
  assign o_isr_done  = r_isr_done;
  assign o_prefix    = r_prefix;
  assign o_jmp_hit   = r_jmp_hit;
  assign o_io_dir    = r_io_dir;
  assign o_fetch_cnt = r_fetch_cnt;

`ifdef OPCODE_HIST_EN
  localparam logic [AW-1:0] PTR_ONE = 1;

  logic [7:0]    r_hist [HIST_DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] w_rd_ptr;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wptr <= '0;
      for (int i = 0; i < HIST_DEPTH; i++) r_hist[i] <= 8'h00;
    end else if (w_done) begin
      r_hist[r_wptr] <= w_byte;
      r_wptr         <= r_wptr + PTR_ONE;
    end
  end

  // Index 0 is the most recently written entry
  assign w_rd_ptr       = r_wptr - PTR_ONE - i_hist_rd_idx;
  assign o_hist_rd_data = r_hist[w_rd_ptr];
`else
  logic w_unused_idx;
  assign w_unused_idx   = ^i_hist_rd_idx;
  assign o_hist_rd_data = 8'h00;
`endif

endmodule
